id_stage_reg: RTL
=================

ID_STAGE_REG -- requirements
Module: id_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, datapath word width (PC, Val_Rn, Val_Rm).
REQ-002 Parameter REG_ADDR_W, default 4, register-file address width (dest, src1, src2).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  taken branch in EXE; squash the captured instruction.
REQ-006 freeze  input  1  downstream stall; hold all register contents.
REQ-007 wb_en_in, mem_read_in, mem_write_in, b_in, s_in  input  1 each  decoded control bits from the control unit.
REQ-008 exe_cmd_in  input  4  ALU command from the control unit.
REQ-009 pc_in, val_rn_in, val_rm_in  input  DATA_W each  PC+4 and register-file read values.
REQ-010 imm_in  input  1; shift_operand_in  input  12; signed_imm_24_in  input  24  instruction fields.
REQ-011 dest_in, src1_in, src2_in  input  REG_ADDR_W each  destination and source register numbers.
REQ-012 carry_in  input  1  C flag from the status register, sampled with the instruction.
REQ-013 Outputs: one registered *_out per input in REQ-007..REQ-012, same width, plus valid_out (1) marking a real instruction.

Function
REQ-014 Per-edge priority SHALL be: rst > flush > freeze > load.
REQ-015 Load (flush=0, freeze=0) SHALL capture every *_in into its *_out on the rising edge and set valid_out=1; latency exactly 1 cycle.
REQ-016 Flush SHALL, on the rising edge, clear every output, including valid_out, to 0, producing a bubble (NOP: wb_en/mem_read/mem_write/b/s all 0).
REQ-017 Flush asserted together with freeze SHALL still clear; flush wins.
REQ-018 Freeze (flush=0) SHALL hold every output, including valid_out, unchanged for as many cycles as it stays high.
REQ-019 Inputs SHALL be captured bit-exact with no transformation; don't-care exe_cmd values from branch decode SHALL be stored as received.
REQ-020 Outputs SHALL be driven only from registers; no combinational input-to-output path.
REQ-021 A valid_out=0 entry SHALL carry wb_en_out=mem_read_out=mem_write_out=b_out=s_out=0.
REQ-022 Consecutive loads SHALL accept a new instruction every cycle (full throughput, no internal back-pressure).

Reset
REQ-023 rst high SHALL immediately, independent of clk, force every output, including valid_out, to 0.
REQ-024 rst asserted mid-freeze or mid-flush SHALL override both; the first edge after deassertion SHALL follow REQ-014 normally.

Structure
REQ-025 The EXE_CMD width and encodings and the REG_ADDR_W/DATA_W defaults SHALL live in the shared ARM package used by the control unit and ALU.
REQ-026 A single parameterised sub-module pipe_reg (width, clk, rst, clr, en, d, q) SHALL implement each field; id_stage_reg instantiates it per field group.

Verification
REQ-027 Reset: rst=1 at arbitrary time with outputs nonzero -> all outputs 0 before the next clk edge.
REQ-028 Load: exe_cmd_in=4'b0000, wb_en_in=1, s_in=1, pc_in=32'h0000_0010, dest_in=4'd3 -> next edge exe_cmd_out=0, wb_en_out=1, s_out=1, pc_out=32'h10, dest_out=3, valid_out=1.
REQ-029 Freeze: after the load in REQ-028, freeze=1 for 3 cycles while inputs change to pc_in=32'h14 -> outputs stay pc_out=32'h10 for all 3 cycles; load resumes the cycle after freeze drops.
REQ-030 Flush: mem_write_in=1, exe_cmd_in=4'b1100, flush=1 -> next edge mem_write_out=0, exe_cmd_out=0, valid_out=0.
REQ-031 Flush+freeze: both high with wb_en_out=1 held -> next edge all outputs 0.
REQ-032 Throughput: 8 back-to-back instructions with pc_in 0,4,...,28 -> pc_out follows 1 cycle later, no drops, valid_out=1 throughout.

Source files
------------

// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared ARM pipeline definitions: widths, EXE_CMD encodings, control bundle
package arm_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 4;
    localparam int EXE_CMD_W      = 4;
    localparam int SHIFT_OP_W     = 12;
    localparam int SIMM_W         = 24;

    // ALU command encodings; CMP/TST/LDR/STR reuse SUB/AND/ADD codes
    localparam logic [EXE_CMD_W-1:0] EXE_NOP = 4'b0000;
    localparam logic [EXE_CMD_W-1:0] EXE_MOV = 4'b0001;
    localparam logic [EXE_CMD_W-1:0] EXE_ADD = 4'b0010;
    localparam logic [EXE_CMD_W-1:0] EXE_ADC = 4'b0011;
    localparam logic [EXE_CMD_W-1:0] EXE_SUB = 4'b0100;
    localparam logic [EXE_CMD_W-1:0] EXE_SBC = 4'b0101;
    localparam logic [EXE_CMD_W-1:0] EXE_AND = 4'b0110;
    localparam logic [EXE_CMD_W-1:0] EXE_ORR = 4'b0111;
    localparam logic [EXE_CMD_W-1:0] EXE_EOR = 4'b1000;
    localparam logic [EXE_CMD_W-1:0] EXE_MVN = 4'b1001;

    typedef struct packed {
        logic                 wb_en;
        logic                 mem_read;
        logic                 mem_write;
        logic                 b;
        logic                 s;
        logic [EXE_CMD_W-1:0] exe_cmd;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - clearable, enabled pipeline register with async active-high reset
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // clr beats en so a squash still lands while the stage is stalled
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/id_stage_reg.sv
// rtl/id_stage_reg.sv - ID/EXE pipeline register: flush squashes to a bubble, freeze holds
module id_stage_reg
    import arm_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  freeze,
    input  logic                  wb_en_in,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic                  b_in,
    input  logic                  s_in,
    input  logic [EXE_CMD_W-1:0]  exe_cmd_in,
    input  logic [DATA_W-1:0]     pc_in,
    input  logic [DATA_W-1:0]     val_rn_in,
    input  logic [DATA_W-1:0]     val_rm_in,
    input  logic                  imm_in,
    input  logic [SHIFT_OP_W-1:0] shift_operand_in,
    input  logic [SIMM_W-1:0]     signed_imm_24_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    input  logic [REG_ADDR_W-1:0] src1_in,
    input  logic [REG_ADDR_W-1:0] src2_in,
    input  logic                  carry_in,
    output logic                  wb_en_out,
    output logic                  mem_read_out,
    output logic                  mem_write_out,
    output logic                  b_out,
    output logic                  s_out,
    output logic [EXE_CMD_W-1:0]  exe_cmd_out,
    output logic [DATA_W-1:0]     pc_out,
    output logic [DATA_W-1:0]     val_rn_out,
    output logic [DATA_W-1:0]     val_rm_out,
    output logic                  imm_out,
    output logic [SHIFT_OP_W-1:0] shift_operand_out,
    output logic [SIMM_W-1:0]     signed_imm_24_out,
    output logic [REG_ADDR_W-1:0] dest_out,
    output logic [REG_ADDR_W-1:0] src1_out,
    output logic [REG_ADDR_W-1:0] src2_out,
    output logic                  carry_out,
    output logic                  valid_out
);

    localparam int FIELD_W = 1 + SHIFT_OP_W + SIMM_W + 1;

    ctrl_t               ctrl_in;
    ctrl_t               ctrl_out;
    logic                load_en;
    logic [FIELD_W-1:0]  field_out;
    logic [3*DATA_W-1:0] data_out;
    logic [3*REG_ADDR_W-1:0] regs_out;

    assign load_en = ~freeze;

    always_comb begin
        ctrl_in           = '0;
        ctrl_in.wb_en     = wb_en_in;
        ctrl_in.mem_read  = mem_read_in;
        ctrl_in.mem_write = mem_write_in;
        ctrl_in.b         = b_in;
        ctrl_in.s         = s_in;
        ctrl_in.exe_cmd   = exe_cmd_in;
    end

    pipe_reg #(.W(CTRL_W)) u_ctrl (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .en  (load_en),
        .d   (ctrl_in),
        .q   (ctrl_out)
    );

    pipe_reg #(.W(3*DATA_W)) u_data (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .en  (load_en),
        .d   ({pc_in, val_rn_in, val_rm_in}),
        .q   (data_out)
    );

    pipe_reg #(.W(FIELD_W)) u_field (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .en  (load_en),
        .d   ({imm_in, shift_operand_in, signed_imm_24_in, carry_in}),
        .q   (field_out)
    );

    pipe_reg #(.W(3*REG_ADDR_W)) u_regs (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .en  (load_en),
        .d   ({dest_in, src1_in, src2_in}),
        .q   (regs_out)
    );

    // Every load is a real instruction; reset and flush leave a zero, i.e. a bubble
    pipe_reg #(.W(1)) u_valid (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .en  (load_en),
        .d   (1'b1),
        .q   (valid_out)
    );

    assign wb_en_out     = ctrl_out.wb_en;
    assign mem_read_out  = ctrl_out.mem_read;
    assign mem_write_out = ctrl_out.mem_write;
    assign b_out         = ctrl_out.b;
    assign s_out         = ctrl_out.s;
    assign exe_cmd_out   = ctrl_out.exe_cmd;

    assign {pc_out, val_rn_out, val_rm_out} = data_out;
    assign {imm_out, shift_operand_out, signed_imm_24_out, carry_out} = field_out;
    assign {dest_out, src1_out, src2_out} = regs_out;

endmodule
